// File: rtl/fetch_pkg.sv
// Shared types and constants for the ATLAS instruction fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small PC/instruction FIFO toward decode; flush beats push, head is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wr_entry,
    output fetch_entry_t                 rd_entry,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_entry = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
            count_q  <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && !flush && wr_ptr_q == PTR_W'(gi)) begin
                mem_q[gi] <= wr_entry;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC generation, 1-cycle icache handshake with miss hold,
// redirect handling (including redirects latched mid-miss) and a decode FIFO.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] ic_addr,
    input  logic [XLEN-1:0] ic_data,
    input  logic            ic_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  resp_pc_q;
    logic             resp_vld_q;
    logic             redir_pend_q;
    logic [XLEN-1:0]  redir_pc_q;

    logic [XLEN-1:0]  redirect_pc_al;
    logic             eff_redirect;
    logic [XLEN-1:0]  eff_target;
    logic             space;
    logic             capture;
    logic             replay;
    logic             pop;
    logic             flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    assign redirect_pc_al = {redirect_pc[XLEN-1:2], 2'b00};
    assign eff_redirect   = redirect_valid | redir_pend_q;
    assign eff_target     = redirect_valid ? redirect_pc_al : redir_pc_q;

    assign dec_valid = ~fifo_empty & ~redirect_valid;
    assign pop       = dec_valid & dec_ready;
    assign space     = (fifo_count < CNT_W'(FIFO_DEPTH)) | pop;
    assign capture   = ~ic_stall & resp_vld_q & ~eff_redirect & space;
    assign replay    = ~ic_stall & resp_vld_q & ~eff_redirect & fifo_full & ~pop;
    // A pending redirect is applied (and flushes) on the first cycle after the miss.
    assign flush     = redirect_valid | (redir_pend_q & ~ic_stall);

    // The icache latches its miss address, so it must not move during a stall.
    always_comb begin
        ic_addr = fetch_pc_q;
        if (ic_stall) begin
            ic_addr = resp_pc_q;
        end else if (eff_redirect) begin
            ic_addr = eff_target;
        end else if (replay) begin
            ic_addr = resp_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_vld_q   <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
        end else if (ic_stall) begin
            if (redirect_valid) begin
                redir_pend_q <= 1'b1;
                redir_pc_q   <= redirect_pc_al;
            end
        end else begin
            resp_pc_q    <= ic_addr;
            resp_vld_q   <= 1'b1;
            redir_pend_q <= 1'b0;
            fetch_pc_q   <= replay ? fetch_pc_q : ic_addr + INSTR_BYTES;
        end
    end

    assign push_entry = '{pc: resp_pc_q, instr: ic_data};
    assign dec_pc     = head_entry.pc;
    assign dec_instr  = head_entry.instr;

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (capture),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (push_entry),
        .rd_entry (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: icache model, expected-PC scoreboard on the decode side.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ic_addr;
    logic [31:0] ic_data;
    logic        ic_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    logic [31:0] last_addr;
    logic [31:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          found;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_addr        (ic_addr),
        .ic_data        (ic_data),
        .ic_stall       (ic_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    // Icache model: 1-cycle latency, garbage data while stalled.
    always @(posedge clk) last_addr <= ic_addr;
    assign ic_data = ic_stall ? 32'hDEAD_BEEF : (last_addr ^ KEY);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Decode-side monitor: every accepted head is compared with the scoreboard.
    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready && sb_q.size() != 0) begin
            logic [31:0] exp_pc;
            exp_pc = sb_q.pop_front();
            $display("dec pc=%h instr=%h expected_pc=%h", dec_pc, dec_instr, exp_pc);
            check("dec_pc", dec_pc, exp_pc);
            check("dec_instr", dec_instr, exp_pc ^ KEY);
        end
    end

    initial begin
        rst_n = 1'b0;
        ic_stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = 1'b1;
        @(negedge clk);
        check("rst_ic_addr", ic_addr, 32'h0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);

        // 1: sequential fetch from reset
        push_seq(32'h0, 8);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("seq_ic_addr", ic_addr, 32'(4 * k));
            if (k < 4) tick();
        end

        // 2: miss while the response for 0x10 is due
        tick();
        ic_stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_ic_addr", ic_addr, 32'h10);
            if (s == 4) check("stall_no_push", 32'(dec_valid), 32'd0);
            tick();
        end
        ic_stall = 1'b0;
        @(negedge clk);
        check("post_stall_ic_addr", ic_addr, 32'h14);
        drain("drain_seq");

        // 3: reset mid-miss, then backpressure with replay
        sb_q.delete();
        dec_ready = 1'b0;
        ic_stall = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_ic_addr", ic_addr, 32'h0);
        check("rst2_dec_valid", 32'(dec_valid), 32'd0);
        tick();
        ic_stall = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 5) begin
                check("bp_replay_addr", ic_addr, 32'h8);
                check("bp_dec_valid", 32'(dec_valid), 32'd1);
                check("bp_head_pc", dec_pc, 32'h0);
            end
            tick();
        end
        push_seq(32'h0, 5);
        dec_ready = 1'b1;
        drain("drain_bp");

        // 4: redirect with a full FIFO
        dec_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("full_dec_valid", 32'(dec_valid), 32'd1);
        tick();
        sb_q.delete();
        push_seq(32'h200, 3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        dec_ready = 1'b1;
        @(negedge clk);
        check("redir_dec_valid", 32'(dec_valid), 32'd0);
        check("redir_ic_addr", ic_addr, 32'h200);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("flushed_dec_valid", 32'(dec_valid), 32'd0);
        check("redir_next_addr", ic_addr, 32'h204);
        drain("drain_redir");

        // 5: two redirects during a miss; the latest wins after the fill
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ic_addr == 32'h220) found = 1'b1;
            else tick();
        end
        check("reach_0x220", 32'(found), 32'd1);
        tick();
        ic_stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            redirect_valid = (s == 1 || s == 3);
            redirect_pc = (s == 1) ? 32'h300 : 32'h400;
            if (redirect_valid) sb_q.delete();
            if (s == 3) push_seq(32'h400, 3);
            @(negedge clk);
            check("miss_redir_ic_addr", ic_addr, 32'h220);
            if (redirect_valid) check("miss_redir_dec_valid", 32'(dec_valid), 32'd0);
            tick();
        end
        redirect_valid = 1'b0;
        ic_stall = 1'b0;
        @(negedge clk);
        check("pend_redir_addr", ic_addr, 32'h400);
        drain("drain_pend");

        // 6: wrap-around and misaligned redirect target
        tick();
        sb_q.delete();
        push_seq(32'hFFFF_FFFC, 3);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_ic_addr", ic_addr, 32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        drain("drain_wrap");
        tick();
        sb_q.delete();
        push_seq(32'h100, 2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        check("align_ic_addr", ic_addr, 32'h100);
        tick();
        redirect_valid = 1'b0;
        drain("drain_align");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
